// File: rtl/iq_frame_capture_pkg.sv
// iq_frame_capture_pkg: shared sample width, default geometry and FSM encodings for the frame capture block
package iq_frame_capture_pkg;
  localparam int IQ_DATA_W = 12;
  localparam int IQ_ADDR_W = 10;
  localparam int IQ_FRAME_LEN = 1024;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_FP = 3'd1,
    CAPTURE = 3'd2,
    READY   = 3'd3,
    READOUT = 3'd4
  } state_t;
endpackage

// File: rtl/iq_frame_capture_if.sv
// iq_frame_capture_if: valid/ready replay stream of I/Q samples
// idata/qdata: sample pair, valid/ready: handshake, last: final sample of the frame
interface iq_frame_capture_if
  import iq_frame_capture_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W
);
  logic [DATA_W-1:0] idata;
  logic [DATA_W-1:0] qdata;
  logic valid;
  logic ready;
  logic last;
  modport master (output idata, qdata, valid, last, input ready);
  modport slave (input idata, qdata, valid, last, output ready);
endinterface

// File: rtl/iq_capture_ram.sv
// iq_capture_ram: simple dual-port frame buffer, registered read with one cycle latency
// i_clk_125p: clock, we/waddr/wdata: write port, raddr/rdata: read port
module iq_capture_ram #(
  parameter int WIDTH = 24,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk_125p,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];
  always_ff @(posedge i_clk_125p) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/iq_frame_capture.sv
// iq_frame_capture: snapshots one frame of I/Q samples and replays it over a valid/ready stream
// i_clk_125p/i_rst_n: clock and async active-low reset
// i_idata/i_qdata/i_iqdata_fp/i_iq_valid: live sample stream with frame pulse
// i_arm/i_abort/i_rd_start: control pulses; rd: replay stream master
// o_done: frame held, o_frame_err: sticky resync flag, o_wr_cnt: samples captured, o_state: FSM state
module iq_frame_capture
  import iq_frame_capture_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W,
  parameter int ADDR_W = IQ_ADDR_W,
  parameter int FRAME_LEN = IQ_FRAME_LEN
) (
  input  logic              i_clk_125p,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_idata,
  input  logic [DATA_W-1:0] i_qdata,
  input  logic              i_iqdata_fp,
  input  logic              i_iq_valid,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic              i_rd_start,
  iq_frame_capture_if.master rd,
  output logic              o_done,
  output logic              o_frame_err,
  output logic [ADDR_W:0]   o_wr_cnt,
  output logic [2:0]        o_state
);
  localparam logic [ADDR_W:0] FL = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] LAST = FL - 1'b1;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t state;
  logic [ADDR_W:0] wr_cnt, rd_cnt;
  logic [2*DATA_W-1:0] ram_q, out_d, skid_d;
  logic q_vld, q_last, out_vld, out_last, skid_vld, skid_last;
  logic samp, we, start, pop, room, issue;
  logic [ADDR_W-1:0] waddr, raddr;
  assign samp = i_iq_valid && !i_abort;
  assign we = samp && ((state == WAIT_FP && i_iqdata_fp) || state == CAPTURE);
  // a frame pulse always restarts the frame at address 0
  assign waddr = (state == CAPTURE && !i_iqdata_fp) ? wr_cnt[ADDR_W-1:0] : '0;
  // arm wins over rd_start when both arrive in READY
  assign start = state == READY && i_rd_start && !i_arm && !i_abort;
  assign pop = out_vld && rd.ready;
  // a new read may issue only if its data is guaranteed a slot in the 2-entry skid when it lands
  assign room = 2'(out_vld) + 2'(skid_vld) + 2'(q_vld) - 2'(pop) <= 2'd1;
  assign issue = start || (state == READOUT && !i_abort && rd_cnt != FL && room);
  assign raddr = start ? '0 : rd_cnt[ADDR_W-1:0];
  iq_capture_ram #(.WIDTH(2*DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .i_clk_125p(i_clk_125p),
    .we(we),
    .waddr(waddr),
    .wdata({i_idata, i_qdata}),
    .raddr(raddr),
    .rdata(ram_q)
  );
  assign rd.idata = out_d[2*DATA_W-1:DATA_W];
  assign rd.qdata = out_d[DATA_W-1:0];
  assign rd.valid = out_vld;
  assign rd.last = out_last;
  assign o_wr_cnt = wr_cnt;
  assign o_state = state;
  always_ff @(posedge i_clk_125p or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      o_done <= 1'b0;
      o_frame_err <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      q_vld <= 1'b0;
      q_last <= 1'b0;
      out_vld <= 1'b0;
      out_last <= 1'b0;
      out_d <= '0;
      skid_vld <= 1'b0;
      skid_last <= 1'b0;
      skid_d <= '0;
    end else if (i_abort) begin
      state <= IDLE;
      o_done <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      q_vld <= 1'b0;
      out_vld <= 1'b0;
      out_last <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      q_vld <= issue;
      q_last <= {1'b0, raddr} == LAST;
      if (issue) rd_cnt <= start ? ONE : rd_cnt + 1'b1;
      // output slot refills from the skid first, so order is preserved
      if (!out_vld || pop) begin
        out_vld <= skid_vld || q_vld;
        out_d <= skid_vld ? skid_d : ram_q;
        out_last <= skid_vld ? skid_last : q_last;
        skid_vld <= skid_vld && q_vld;
        if (skid_vld) begin
          skid_d <= ram_q;
          skid_last <= q_last;
        end
      end else if (q_vld) begin
        skid_vld <= 1'b1;
        skid_d <= ram_q;
        skid_last <= q_last;
      end
      case (state)
        IDLE, READY:
          if (i_arm) begin
            state <= WAIT_FP;
            o_done <= 1'b0;
            o_frame_err <= 1'b0;
            wr_cnt <= '0;
          end else if (start) begin
            state <= READOUT;
            o_done <= 1'b0;
          end
        WAIT_FP:
          if (samp && i_iqdata_fp) begin
            wr_cnt <= ONE;
            state <= FRAME_LEN == 1 ? READY : CAPTURE;
            o_done <= FRAME_LEN == 1;
          end
        CAPTURE:
          if (samp) begin
            if (i_iqdata_fp) begin
              o_frame_err <= 1'b1;
              wr_cnt <= ONE;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
              if (wr_cnt == LAST) begin
                state <= READY;
                o_done <= 1'b1;
              end
            end
          end
        READOUT:
          if (pop && out_last) begin
            state <= READY;
            o_done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iq_frame_capture.sv
// tb_iq_frame_capture: directed capture/replay vectors with hand-computed expectations
module tb_iq_frame_capture;
  localparam int FL = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] idata = '0, qdata = '0;
  logic fp = 1'b0, iqv = 1'b0, arm = 1'b0, abort = 1'b0, rd_start = 1'b0;
  logic done, ferr;
  logic [10:0] wr_cnt;
  logic [2:0] st;
  int vectors = 0;
  int miscompares = 0;
  iq_frame_capture_if #(.DATA_W(12)) rd_if ();
  iq_frame_capture #(.DATA_W(12), .ADDR_W(10), .FRAME_LEN(FL)) dut (
    .i_clk_125p(clk),
    .i_rst_n(rst_n),
    .i_idata(idata),
    .i_qdata(qdata),
    .i_iqdata_fp(fp),
    .i_iq_valid(iqv),
    .i_arm(arm),
    .i_abort(abort),
    .i_rd_start(rd_start),
    .rd(rd_if),
    .o_done(done),
    .o_frame_err(ferr),
    .o_wr_cnt(wr_cnt),
    .o_state(st)
  );
  always #4 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [11:0] n, input logic f, input logic v);
    idata = n;
    qdata = ~n;
    fp = f;
    iqv = v;
    tick();
    fp = 1'b0;
    iqv = 1'b0;
  endtask
  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic capture(input int base);
    pulse_arm();
    drive(12'(base), 1'b1, 1'b1);
    for (int n = 1; n < FL; n++) drive(12'(base + n), 1'b0, 1'b1);
    check("cap_done", 32'(done), 32'd1);
  endtask
  task automatic readout(input int base, input bit rnd);
    int k, cyc, first;
    bit stall;
    logic [11:0] hi, hq, e, eq;
    logic hl;
    k = 0;
    first = -1;
    stall = 1'b0;
    hi = '0;
    hq = '0;
    hl = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("rd_lat1", 32'(rd_if.valid), 32'd0);
    for (cyc = 1; cyc < 300 && k < FL; cyc++) begin
      rd_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        check("stall_v", 32'(rd_if.valid), 32'd1);
        check("stall_i", 32'(rd_if.idata), 32'(hi));
        check("stall_q", 32'(rd_if.qdata), 32'(hq));
        check("stall_l", 32'(rd_if.last), 32'(hl));
      end
      if (rd_if.valid && first < 0) first = cyc;
      if (rd_if.valid && rd_if.ready) begin
        e = 12'(base + k);
        eq = ~e;
        check("rd_i", 32'(rd_if.idata), 32'(e));
        check("rd_q", 32'(rd_if.qdata), 32'(eq));
        check("rd_last", 32'(rd_if.last), 32'(k == FL - 1));
        k++;
      end
      stall = rd_if.valid && !rd_if.ready;
      hi = rd_if.idata;
      hq = rd_if.qdata;
      hl = rd_if.last;
      tick();
    end
    check("rd_count", 32'(k), 32'(FL));
    if (!rnd) begin
      check("rd_first", 32'(first), 32'd2);
      check("rd_burst", 32'(cyc - first), 32'(FL));
    end
    check("rd_state", 32'(st), 32'd3);
    check("rd_vdrop", 32'(rd_if.valid), 32'd0);
    check("rd_done", 32'(done), 32'd1);
    rd_if.ready = 1'b0;
  endtask
  initial begin
    rd_if.ready = 1'b0;
    repeat (4) begin
      idata = 12'($urandom);
      qdata = 12'($urandom);
      fp = 1'($urandom);
      iqv = 1'($urandom);
      arm = 1'($urandom);
      abort = 1'($urandom);
      rd_start = 1'($urandom);
      rd_if.ready = 1'($urandom);
      tick();
    end
    check("rst_state", 32'(st), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_wrcnt", 32'(wr_cnt), 32'd0);
    check("rst_valid", 32'(rd_if.valid), 32'd0);
    check("rst_last", 32'(rd_if.last), 32'd0);
    check("rst_data", 32'({rd_if.idata, rd_if.qdata}), 32'd0);
    {fp, iqv, arm, abort, rd_start, rd_if.ready} = '0;
    rst_n = 1'b1;
    tick();
    pulse_arm();
    check("arm_state", 32'(st), 32'd1);
    check("arm_done", 32'(done), 32'd0);
    for (int n = 90; n < 100; n++) drive(12'(n), 1'b0, 1'b1);
    check("wait_nofp", 32'(st), 32'd1);
    drive(12'd100, 1'b1, 1'b1);
    check("fp_state", 32'(st), 32'd2);
    check("fp_wrcnt", 32'(wr_cnt), 32'd1);
    for (int n = 101; n < 115; n++) drive(12'(n), 1'b0, 1'b1);
    check("cap_wrcnt", 32'(wr_cnt), 32'd15);
    check("cap_notdone", 32'(done), 32'd0);
    drive(12'd115, 1'b0, 1'b1);
    check("full_state", 32'(st), 32'd3);
    check("full_done", 32'(done), 32'd1);
    check("full_wrcnt", 32'(wr_cnt), 32'd16);
    drive(12'd116, 1'b1, 1'b1);
    drive(12'd117, 1'b0, 1'b1);
    check("ready_hold", 32'(wr_cnt), 32'd16);
    check("ready_ferr", 32'(ferr), 32'd0);
    readout(100, 1'b0);
    readout(100, 1'b1);
    pulse_arm();
    check("rearm_state", 32'(st), 32'd1);
    drive(12'd200, 1'b1, 1'b1);
    for (int n = 201; n < 205; n++) drive(12'(n), 1'b0, 1'b1);
    check("pre_err", 32'(ferr), 32'd0);
    drive(12'd205, 1'b1, 1'b1);
    check("err_set", 32'(ferr), 32'd1);
    check("err_wrcnt", 32'(wr_cnt), 32'd1);
    check("err_state", 32'(st), 32'd2);
    for (int n = 206; n < 221; n++) drive(12'(n), 1'b0, 1'b1);
    check("err_done", 32'(done), 32'd1);
    readout(205, 1'b0);
    check("err_sticky", 32'(ferr), 32'd1);
    pulse_arm();
    check("err_clear", 32'(ferr), 32'd0);
    drive(12'd299, 1'b1, 1'b0);
    check("fp_novalid", 32'(st), 32'd1);
    for (int k = 0; k < FL; k++) begin
      drive(12'(300 + k), k == 0, 1'b1);
      check("gap_wrcnt", 32'(wr_cnt), 32'(k + 1));
      for (int g = 0; g < k % 4; g++) drive(12'hABC, 1'b1, 1'b0);
    end
    check("gap_done", 32'(done), 32'd1);
    check("gap_ferr", 32'(ferr), 32'd0);
    readout(300, 1'b0);
    pulse_arm();
    drive(12'd400, 1'b1, 1'b1);
    for (int n = 401; n < 405; n++) drive(12'(n), 1'b0, 1'b1);
    check("ab_cap_state", 32'(st), 32'd2);
    check("ab_cap_wrcnt", 32'(wr_cnt), 32'd5);
    abort = 1'b1;
    arm = 1'b1;
    tick();
    {abort, arm} = '0;
    check("ab_cap_idle", 32'(st), 32'd0);
    check("ab_cap_wrclr", 32'(wr_cnt), 32'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("idle_start", 32'(st), 32'd0);
    check("idle_novalid", 32'(rd_if.valid), 32'd0);
    capture(500);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("ab_rd_valid", 32'(rd_if.valid), 32'd1);
    check("ab_rd_data", 32'(rd_if.idata), 32'd500);
    tick();
    check("ab_rd_hold", 32'(rd_if.idata), 32'd500);
    abort = 1'b1;
    arm = 1'b1;
    tick();
    {abort, arm} = '0;
    check("ab_rd_vdrop", 32'(rd_if.valid), 32'd0);
    check("ab_rd_idle", 32'(st), 32'd0);
    check("ab_rd_done", 32'(done), 32'd0);
    rd_if.ready = 1'b1;
    tick();
    check("ab_rd_flush", 32'(rd_if.valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
